// File: rtl/sm83_bus_pkg.sv
// Shared types and helpers for the SM83 bus sequencer.
package sm83_bus_pkg;

  typedef enum logic [2:0] {T1, T2, TW, T3, T4} tstate_t;

  // Wait-counter width; never narrower than one bit so MAX_WAIT=0 still elaborates.
  function automatic int wait_cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/sm83_tstate_gen.sv
// T-state phase generator with bounded wait-state insertion and TW counter.
//   state | meaning
//   T1    | address phase
//   T2    | strobe setup, ext_wait sampled
//   TW    | wait state, core stalled, ext_wait sampled
//   T3    | data phase
//   T4    | data capture, next request sampled
module sm83_tstate_gen
  import sm83_bus_pkg::*;
#(
  parameter int MAX_WAIT = 3,
  parameter int CW       = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          seq_active,
  input  logic          ext_wait,
  output logic          t1,
  output logic          t2,
  output logic          t3,
  output logic          t4,
  output logic          stall,
  output logic [CW-1:0] tw_count
);

  localparam logic [CW:0] MAX_W = (CW+1)'(MAX_WAIT);

  tstate_t     state;
  tstate_t     state_nxt;
  logic [CW:0] cnt_inc;

  assign cnt_inc = {1'b0, tw_count} + (CW+1)'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= T1;
      tw_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == TW)
        tw_count <= cnt_inc[CW-1:0];
      else if (state == T4)
        tw_count <= '0;
    end
  end

  // cnt_inc already counts the TW being left, so hitting MAX_WAIT forces T3.
  always_comb begin
    state_nxt = state;
    unique case (state)
      T1:      state_nxt = T2;
      T2:      state_nxt = (seq_active && ext_wait && (MAX_WAIT > 0)) ? TW : T3;
      TW:      state_nxt = (ext_wait && (cnt_inc < MAX_W)) ? TW : T3;
      T3:      state_nxt = T4;
      T4:      state_nxt = T1;
      default: state_nxt = T1;
    endcase
  end

  assign t1    = (state == T1);
  assign t2    = (state == T2);
  assign t3    = (state == T3);
  assign t4    = (state == T4);
  assign stall = (state == TW);

endmodule

// File: rtl/sm83_bus_seq.sv
// SM83 memory-interface sequencer: bus strobes, address/data latches and
// opcode capture around the T-state generator.
module sm83_bus_seq
  import sm83_bus_pkg::*;
#(
  parameter int ADR_WIDTH = 16,
  parameter int WORD_SIZE = 8,
  parameter int MAX_WAIT  = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  mread,
  input  logic                                  mwrite,
  input  logic                                  ext_wait,
  output logic                                  t1,
  output logic                                  t2,
  output logic                                  t3,
  output logic                                  t4,
  output logic                                  stall,
  output logic [ADR_WIDTH-1:0]                  aout,
  input  logic [ADR_WIDTH-1:0]                  ain,
  input  logic                                  apin_we,
  input  logic [WORD_SIZE-1:0]                  din,
  input  logic                                  dl_we,
  output logic [WORD_SIZE-1:0]                  dout,
  input  logic [WORD_SIZE-1:0]                  ext_din,
  output logic [WORD_SIZE-1:0]                  ext_dout,
  output logic                                  ext_data_lh,
  output logic                                  n_rd,
  output logic                                  p_rd,
  output logic                                  n_wr,
  output logic                                  p_wr,
  output logic [WORD_SIZE-1:0]                  opcode,
  input  logic                                  ir_we,
  output logic [wait_cnt_width(MAX_WAIT)-1:0]   wait_count,
  output logic                                  proto_err
);

  localparam int CW = wait_cnt_width(MAX_WAIT);

  logic                 rd_seq;
  logic                 wr_seq;
  logic                 rd_t4;
  logic [WORD_SIZE-1:0] data_latch;
  logic [WORD_SIZE-1:0] opcode_q;
  logic [CW-1:0]        tw_count;

  sm83_tstate_gen #(
    .MAX_WAIT (MAX_WAIT),
    .CW       (CW)
  ) u_tstate (
    .clk        (clk),
    .reset      (reset),
    .seq_active (rd_seq | wr_seq),
    .ext_wait   (ext_wait),
    .t1         (t1),
    .t2         (t2),
    .t3         (t3),
    .t4         (t4),
    .stall      (stall),
    .tw_count   (tw_count)
  );

  assign rd_t4 = rd_seq & t4;

  // A simultaneous read/write request keeps the read and flags the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_seq     <= 1'b0;
      wr_seq     <= 1'b0;
      wait_count <= '0;
      proto_err  <= 1'b0;
      data_latch <= '0;
      aout       <= '0;
      opcode_q   <= '0;
    end else begin
      if (t4) begin
        rd_seq     <= mread;
        wr_seq     <= mwrite & ~mread;
        wait_count <= tw_count;
        if (mread && mwrite)
          proto_err <= 1'b1;
      end
      if (dl_we)
        data_latch <= din;
      else if (rd_t4)
        data_latch <= ext_din;
      if (apin_we)
        aout <= ain;
      else if (t4)
        aout[ADR_WIDTH-1:8] <= '0;
      if (ir_we)
        opcode_q <= ext_din;
    end
  end

  assign dout     = rd_t4 ? ext_din : data_latch;
  assign ext_dout = data_latch;
  assign opcode   = ir_we ? ext_din : opcode_q;

  // Strobes are forced inactive while reset is held, even mid-write.
  always_comb begin
    n_rd        = 1'b1;
    p_rd        = 1'b1;
    n_wr        = 1'b0;
    p_wr        = 1'b0;
    ext_data_lh = 1'b0;
    if (!reset) begin
      if (wr_seq) begin
        n_rd = 1'b0;
        p_rd = t4;
        n_wr = t3;
        p_wr = t2 | stall | t3;
      end
      ext_data_lh = rd_seq & t3;
    end
  end

endmodule

// File: tb/tb_sm83_bus_seq.sv
// Scoreboard bench for sm83_bus_seq: driver pushes per-cycle expectations,
// monitor pops them at every observed T4.
module tb_sm83_bus_seq;

  localparam int MAXW = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mread = 1'b0, mwrite = 1'b0, ext_wait = 1'b0;
  logic        t1, t2, t3, t4, stall;
  logic [15:0] aout;
  logic [15:0] ain = '0;
  logic        apin_we = 1'b0;
  logic [7:0]  din = '0, ext_din = '0;
  logic [7:0]  dout, ext_dout, opcode;
  logic        dl_we = 1'b0, ir_we = 1'b0;
  logic        ext_data_lh, n_rd, p_rd, n_wr, p_wr;
  logic [1:0]  wait_count;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  // kind: 0 idle, 1 read, 2 write
  typedef struct {
    int          kind;
    int          n;
    logic [7:0]  dout_t4;
    logic [7:0]  opc_t4;
    logic [7:0]  dl_mid;
    logic [7:0]  edout;
    logic [15:0] aout_t4;
    bit          perr;
  } exp_t;

  exp_t exp_q[$];

  int          m_kind;
  logic [7:0]  m_latch, m_opc;
  logic [15:0] m_aout;
  bit          m_perr;

  always #5 clk = ~clk;

  sm83_bus_seq #(.ADR_WIDTH(16), .WORD_SIZE(8), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .mread(mread), .mwrite(mwrite), .ext_wait(ext_wait),
    .t1(t1), .t2(t2), .t3(t3), .t4(t4), .stall(stall),
    .aout(aout), .ain(ain), .apin_we(apin_we), .din(din), .dl_we(dl_we),
    .dout(dout), .ext_din(ext_din), .ext_dout(ext_dout), .ext_data_lh(ext_data_lh),
    .n_rd(n_rd), .p_rd(p_rd), .n_wr(n_wr), .p_wr(p_wr),
    .opcode(opcode), .ir_we(ir_we), .wait_count(wait_count), .proto_err(proto_err)
  );

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Phase index within a cycle of n wait states: 1=T1 2=T2 3=TW 4=T3 5=T4.
  function automatic int exp_phase(input int i, input int n);
    if (i == 0) return 1;
    if (i == 1) return 2;
    if (i <= 1 + n) return 3;
    if (i == 2 + n) return 4;
    return 5;
  endfunction

  function automatic logic [4:0] phase_vec(input int ph);
    return {ph == 1, ph == 2, ph == 3, ph == 4, ph == 5};
  endfunction

  // {n_rd, p_rd, n_wr, p_wr, ext_data_lh}
  function automatic logic [4:0] strobe_vec(input int kind, input int ph);
    if (kind == 2) return {1'b0, ph == 5, ph == 4, (ph >= 2) && (ph <= 4), 1'b0};
    return {1'b1, 1'b1, 1'b0, 1'b0, (kind == 1) && (ph == 4)};
  endfunction

  task automatic model_reset();
    m_kind  = 0;
    m_latch = '0;
    m_opc   = '0;
    m_aout  = '0;
    m_perr  = 1'b0;
  endtask

  // One full bus cycle starting at T1; nrd/nwr are presented in T4 for the next cycle.
  // h = number of clocks ext_wait is held high starting at T2.
  task automatic do_cycle(input bit nrd, input bit nwr, input int h,
                          input bit ldl, input logic [7:0] dv, input bit ir,
                          input bit ap1, input logic [15:0] a1,
                          input bit ap4, input logic [15:0] a4, input logic [7:0] dt4);
    exp_t        r;
    int          n, len;
    bit          irx;
    logic [15:0] a;
    n   = (m_kind == 0) ? 0 : ((h < MAXW) ? h : MAXW);
    len = 4 + n;
    irx = ir && (m_kind == 1);
    r.kind = m_kind;
    r.n    = n;
    if (ldl) m_latch = dv;
    r.dl_mid  = m_latch;
    r.edout   = m_latch;
    r.dout_t4 = (m_kind == 1) ? dt4 : m_latch;
    r.opc_t4  = irx ? dt4 : m_opc;
    a = ap1 ? a1 : m_aout;
    r.aout_t4 = a;
    r.perr    = m_perr;
    exp_q.push_back(r);
    for (int i = 0; i < len; i++) begin
      if (i >= 1 && i <= h && i <= 1 + n) ext_wait = 1'b1;
      else if (i == 0 || i >= 2 + n)      ext_wait = 1'($urandom);
      else                                ext_wait = 1'b0;
      mread   = (i == len - 1) ? nrd : 1'($urandom);
      mwrite  = (i == len - 1) ? nwr : 1'($urandom);
      dl_we   = (i == 0) && ldl;
      din     = (i == 0) ? dv : 8'($urandom);
      ext_din = (i == len - 1) ? dt4 : 8'($urandom);
      ir_we   = (i == len - 1) && irx;
      apin_we = ((i == 0) && ap1) || ((i == len - 1) && ap4);
      ain     = (i == 0) ? a1 : ((i == len - 1) ? a4 : 16'($urandom));
      @(posedge clk);
      #1;
    end
    mread = 1'b0; mwrite = 1'b0; dl_we = 1'b0; ir_we = 1'b0; apin_we = 1'b0;
    if (m_kind == 1) m_latch = dt4;
    if (irx) m_opc = dt4;
    m_aout = ap4 ? a4 : {8'h00, a[7:0]};
    if (nrd && nwr) m_perr = 1'b1;
    m_kind = nrd ? 1 : (nwr ? 2 : 0);
  endtask

  initial begin : monitor
    logic [4:0] ph_obs [16];
    logic [4:0] st_obs [16];
    logic [7:0] ed_obs [16];
    logic [7:0] dout_t3;
    exp_t       r;
    int         idx, prev_n, len, bad, bad_ed, ph;
    idx = 0;
    prev_n = 0;
    dout_t3 = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        idx = 0;
        prev_n = 0;
      end else begin
        if (idx == 0) chk("wait_count", int'(wait_count), prev_n);
        ph_obs[idx] = {t1, t2, stall, t3, t4};
        st_obs[idx] = {n_rd, p_rd, n_wr, p_wr, ext_data_lh};
        ed_obs[idx] = ext_dout;
        if (t3) dout_t3 = dout;
        if (t4) begin
          if (exp_q.size() == 0) begin
            chk("queue_underflow", 1, 0);
          end else begin
            r = exp_q.pop_front();
            len = idx + 1;
            chk("cycle_len", len, 4 + r.n);
            bad = 0;
            bad_ed = 0;
            for (int i = 0; i < len && i < 4 + r.n; i++) begin
              ph = exp_phase(i, r.n);
              if (ph_obs[i] !== phase_vec(ph)) bad++;
              if (st_obs[i] !== strobe_vec(r.kind, ph)) bad++;
              if (r.kind == 2 && ph >= 2 && ph <= 4 && ed_obs[i] !== r.edout) bad_ed++;
            end
            chk("phase_strobe_trace", bad, 0);
            if (r.kind == 2) chk("ext_dout_stable", bad_ed, 0);
            chk("dout_t3", int'(dout_t3), int'(r.dl_mid));
            chk("dout_t4", int'(dout), int'(r.dout_t4));
            chk("opcode_t4", int'(opcode), int'(r.opc_t4));
            chk("aout_t4", int'(aout), int'(r.aout_t4));
            chk("proto_err", int'(proto_err), int'(r.perr));
            prev_n = r.n;
          end
          idx = 0;
        end else if (idx == 15) begin
          chk("cycle_no_t4", idx + 1, 0);
          idx = 0;
        end else begin
          idx++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int         sel, hh;
    bit         rq_rd, rq_wr;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_t1", int'({t1, t2, t3, t4, stall}), 5'b10000);
    chk("rst_strobes", int'({n_rd, p_rd, n_wr, p_wr, ext_data_lh}), 5'b11000);
    chk("rst_aout", int'(aout), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_opcode", int'(opcode), 0);
    chk("rst_wait_count", int'(wait_count), 0);
    chk("rst_proto_err", int'(proto_err), 0);
    reset = 1'b0;

    // idle with ext_wait high, then address load, read, write, stuck-wait read, dual request
    do_cycle(1'b0, 1'b0, 4, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h11);
    do_cycle(1'b1, 1'b0, 4, 1'b0, 8'h00, 1'b0, 1'b1, 16'hFF80, 1'b0, 16'h0000, 8'h22);
    do_cycle(1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'hA5);
    do_cycle(1'b1, 1'b0, 2, 1'b1, 8'h3C, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h33);
    do_cycle(1'b1, 1'b1, 9, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h5A);
    do_cycle(1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hC3C3, 8'h6B);

    for (int k = 0; k < 60; k++) begin
      sel   = $urandom_range(0, 9);
      rq_rd = (sel < 4) || (sel == 9);
      rq_wr = (sel >= 4 && sel < 8) || (sel == 9);
      hh    = $urandom_range(0, 5);
      do_cycle(rq_rd, rq_wr, hh, ($urandom_range(0, 3) != 0), 8'($urandom),
               1'($urandom), 1'($urandom), 16'($urandom),
               ($urandom_range(0, 3) == 0), 16'($urandom), 8'($urandom));
    end

    // write with stuck ext_wait, aborted by reset inside TW
    do_cycle(1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    ext_wait = 1'b1; dl_we = 1'b1; din = 8'h77; apin_we = 1'b1; ain = 16'h1234;
    @(posedge clk); #1;
    dl_we = 1'b0; apin_we = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_tw", int'({stall, p_wr}), 2'b11);
    chk("abort_aout_before", int'(aout), 16'h1234);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_strobes_gated", int'({n_rd, p_rd, n_wr, p_wr, ext_data_lh}), 5'b11000);
    @(posedge clk); #1;
    chk("abort_phase_t1", int'({t1, t2, t3, t4, stall}), 5'b10000);
    chk("abort_aout", int'(aout), 0);
    chk("abort_ext_dout", int'(ext_dout), 0);
    chk("abort_proto_err", int'(proto_err), 0);
    ext_wait = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();

    for (int k = 0; k < 8; k++) begin
      sel = $urandom_range(0, 2);
      do_cycle(sel == 1, sel == 2, $urandom_range(0, 4), 1'b1, 8'($urandom),
               1'($urandom), 1'($urandom), 16'($urandom), 1'b0, 16'h0000, 8'($urandom));
    end
    do_cycle(1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
